// File: rtl/bus_arbiter_2m_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared definitions for the two-master serial-bus arbiter and the master /
// slave modules that talk to it: FSM state encoding, master id constants and
// default field sizes.
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SSEL  = 2'd1,
        ROUTE = 2'd2,
        ERR   = 2'd3
    } arb_state_t;

    localparam logic MASTER_M1 = 1'b0;
    localparam logic MASTER_M2 = 1'b1;

    localparam int DEF_SLAVE_LEN      = 2;
    localparam int DEF_NUM_SLAVES     = 3;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/bus_arbiter_2m_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2m_if
// Request/grant and route-select bundle between the two bus masters and the
// arbiter.
//   master modport : drives requests and serial slave ids, observes grants,
//                    busy and route/status outputs.
//   slave modport  : the arbiter side (receives requests, drives the rest).
// Signals: m1/m2_request, m1/m2_slave_sel, m1/m2_grant, arbiter_busy,
//          master_route, slave_route[SLAVE_LEN], route_valid, arb_error,
//          arb_timeout.
// -----------------------------------------------------------------------------
interface bus_arbiter_2m_if
    import bus_arb_pkg::*;
#(
    parameter int SLAVE_LEN = DEF_SLAVE_LEN
) ();

    logic                 m1_request;
    logic                 m2_request;
    logic                 m1_slave_sel;
    logic                 m2_slave_sel;
    logic                 m1_grant;
    logic                 m2_grant;
    logic                 arbiter_busy;
    logic                 master_route;
    logic [SLAVE_LEN-1:0] slave_route;
    logic                 route_valid;
    logic                 arb_error;
    logic                 arb_timeout;

    modport master (
        output m1_request, m2_request, m1_slave_sel, m2_slave_sel,
        input  m1_grant, m2_grant, arbiter_busy, master_route,
               slave_route, route_valid, arb_error, arb_timeout
    );

    modport slave (
        input  m1_request, m2_request, m1_slave_sel, m2_slave_sel,
        output m1_grant, m2_grant, arbiter_busy, master_route,
               slave_route, route_valid, arb_error, arb_timeout
    );

endinterface

// File: rtl/bus_arbiter_2m_slave_id_shifter.sv
// -----------------------------------------------------------------------------
// slave_id_shifter
// MSB-first shift register for the serial slave id, with a bit counter.
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_clr           : clear register and counter
//   i_shift_en      : accept i_bit this cycle
//   i_bit           : serial id bit
//   o_done          : this cycle's shift completes the id
//   o_id            : id including the bit being shifted in this cycle, so
//                     the caller can act on the complete id at the same edge
// -----------------------------------------------------------------------------
module slave_id_shifter
    import bus_arb_pkg::*;
#(
    parameter int SLAVE_LEN = DEF_SLAVE_LEN
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_shift_en,
    input  logic                 i_bit,
    output logic                 o_done,
    output logic [SLAVE_LEN-1:0] o_id
);

    localparam int CW = $clog2(SLAVE_LEN + 1);

    logic [SLAVE_LEN-1:0] r_shreg;
    logic [CW-1:0]        r_cnt;
    logic [SLAVE_LEN-1:0] w_id;

    // Truncation drops the oldest bit; also works for SLAVE_LEN == 1.
    assign w_id   = SLAVE_LEN'({r_shreg, i_bit});
    assign o_id   = w_id;
    assign o_done = i_shift_en && (r_cnt == CW'(SLAVE_LEN - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (i_shift_en) begin
            r_shreg <= w_id;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter_2m.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2m
// Round-robin arbiter for two serial-bus masters. After a grant the owner
// shifts in a slave id; a valid id opens the route until the owner drops its
// request, an invalid id produces a one-cycle arb_error.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : bus_arbiter_2m_if.slave (requests, ids, grants, route/status)
// Optional: define ARB_TIMEOUT_EN to force release of a route held for
// TIMEOUT_CYCLES cycles (arb_timeout pulse, other master gets priority).
// All outputs are registered.
// -----------------------------------------------------------------------------
module bus_arbiter_2m
    import bus_arb_pkg::*;
#(
    parameter int SLAVE_LEN      = DEF_SLAVE_LEN,
    parameter int NUM_SLAVES     = DEF_NUM_SLAVES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    bus_arbiter_2m_if.slave bus
);

    arb_state_t           r_state, w_state_nx;
    logic                 r_m1_grant, w_m1_grant_nx;
    logic                 r_m2_grant, w_m2_grant_nx;
    logic                 r_busy, w_busy_nx;
    logic                 r_master_route, w_master_route_nx;
    logic [SLAVE_LEN-1:0] r_slave_route, w_slave_route_nx;
    logic                 r_route_valid, w_route_valid_nx;
    logic                 r_arb_error, w_arb_error_nx;
    logic                 r_last_winner, w_last_winner_nx;

    logic                 w_win;
    logic                 w_owner_req;
    logic                 w_owner_bit;
    logic                 w_clr;
    logic                 w_shift_en;
    logic                 w_done;
    logic [SLAVE_LEN-1:0] w_id;

    // On a tie the master that did not win last time gets the bus.
    assign w_win = (bus.m1_request && bus.m2_request) ? ~r_last_winner :
                   (bus.m2_request ? MASTER_M2 : MASTER_M1);

    // master_route already names the owner during SSEL/ROUTE.
    assign w_owner_req = r_master_route ? bus.m2_request   : bus.m1_request;
    assign w_owner_bit = r_master_route ? bus.m2_slave_sel : bus.m1_slave_sel;

    slave_id_shifter #(.SLAVE_LEN(SLAVE_LEN)) u_shifter (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_clr      (w_clr),
        .i_shift_en (w_shift_en),
        .i_bit      (w_owner_bit),
        .o_done     (w_done),
        .o_id       (w_id)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCW-1:0] r_tcnt;
    logic           r_arb_timeout, w_arb_timeout_nx;

    // Counts cycles spent in ROUTE; restarts from zero on every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                r_tcnt <= '0;
        else if (r_state != ROUTE) r_tcnt <= '0;
        else                      r_tcnt <= r_tcnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_arb_timeout <= 1'b0;
        else       r_arb_timeout <= w_arb_timeout_nx;
    end

    assign bus.arb_timeout = r_arb_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign bus.arb_timeout  = 1'b0;
`endif

    always_comb begin
        w_state_nx        = r_state;
        w_m1_grant_nx     = r_m1_grant;
        w_m2_grant_nx     = r_m2_grant;
        w_master_route_nx = r_master_route;
        w_slave_route_nx  = r_slave_route;
        w_route_valid_nx  = r_route_valid;
        w_arb_error_nx    = 1'b0;
        w_last_winner_nx  = r_last_winner;
        w_clr             = 1'b0;
        w_shift_en        = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_arb_timeout_nx  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (bus.m1_request || bus.m2_request) begin
                    w_m1_grant_nx     = (w_win == MASTER_M1);
                    w_m2_grant_nx     = (w_win == MASTER_M2);
                    w_master_route_nx = w_win;
                    w_last_winner_nx  = w_win;
                    w_clr             = 1'b1;
                    w_state_nx        = SSEL;
                end
            end
            SSEL: begin
                if (!w_owner_req) begin
                    // Abort: owner gave up before the id was complete.
                    w_m1_grant_nx = 1'b0;
                    w_m2_grant_nx = 1'b0;
                    w_state_nx    = IDLE;
                end else begin
                    w_shift_en = 1'b1;
                    if (w_done) begin
                        if (int'(w_id) < NUM_SLAVES) begin
                            w_slave_route_nx = w_id;
                            w_route_valid_nx = 1'b1;
                            w_state_nx       = ROUTE;
                        end else begin
                            w_m1_grant_nx  = 1'b0;
                            w_m2_grant_nx  = 1'b0;
                            w_arb_error_nx = 1'b1;
                            w_state_nx     = ERR;
                        end
                    end
                end
            end
            ROUTE: begin
                if (!w_owner_req) begin
                    w_m1_grant_nx    = 1'b0;
                    w_m2_grant_nx    = 1'b0;
                    w_route_valid_nx = 1'b0;
                    w_state_nx       = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                    w_m1_grant_nx    = 1'b0;
                    w_m2_grant_nx    = 1'b0;
                    w_route_valid_nx = 1'b0;
                    w_arb_timeout_nx = 1'b1;
                    w_last_winner_nx = r_master_route;
                    w_state_nx       = IDLE;
                end
`endif
            end
            ERR: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
        w_busy_nx = (w_state_nx != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_m1_grant     <= 1'b0;
            r_m2_grant     <= 1'b0;
            r_busy         <= 1'b0;
            r_master_route <= 1'b0;
            r_slave_route  <= '0;
            r_route_valid  <= 1'b0;
            r_arb_error    <= 1'b0;
            r_last_winner  <= MASTER_M2;
        end else begin
            r_state        <= w_state_nx;
            r_m1_grant     <= w_m1_grant_nx;
            r_m2_grant     <= w_m2_grant_nx;
            r_busy         <= w_busy_nx;
            r_master_route <= w_master_route_nx;
            r_slave_route  <= w_slave_route_nx;
            r_route_valid  <= w_route_valid_nx;
            r_arb_error    <= w_arb_error_nx;
            r_last_winner  <= w_last_winner_nx;
        end
    end

    assign bus.m1_grant     = r_m1_grant;
    assign bus.m2_grant     = r_m2_grant;
    assign bus.arbiter_busy = r_busy;
    assign bus.master_route = r_master_route;
    assign bus.slave_route  = r_slave_route;
    assign bus.route_valid  = r_route_valid;
    assign bus.arb_error    = r_arb_error;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_2m
// Self-checking bench for bus_arbiter_2m: directed scenarios with literal
// expectations, then randomized master behaviour against a transaction-level
// model. Built with TIMEOUT_CYCLES = 8; the forced-release scenario and model
// rule are active when ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_2m;
    import bus_arb_pkg::*;

    localparam int L = 2;
    localparam int N = 3;
    localparam int T = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_2m_if #(.SLAVE_LEN(L)) bus ();

    bus_arbiter_2m #(.SLAVE_LEN(L), .NUM_SLAVES(N), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: phase 0 idle, 1 receiving id, 2 routing, 3 error cycle.
    int   ph, owner, last, bits, idv, rc;
    logic e_g1, e_g2, e_busy, e_mr, e_rv, e_err, e_to;
    int   e_sr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = 0; owner = 0; last = 1; bits = 0; idv = 0; rc = 0;
        e_g1 = 0; e_g2 = 0; e_busy = 0; e_mr = 0; e_rv = 0; e_err = 0; e_to = 0;
        e_sr = 0;
    endtask

    task automatic model_step();
        int r1, r2, s1, s2, req;
        r1 = int'(bus.m1_request);   r2 = int'(bus.m2_request);
        s1 = int'(bus.m1_slave_sel); s2 = int'(bus.m2_slave_sel);
        req = (owner == 1) ? r2 : r1;
        e_err = 0; e_to = 0;
        case (ph)
            0: if (r1 != 0 || r2 != 0) begin
                owner = (r1 != 0 && r2 != 0) ? 1 - last : r2;
                last = owner; e_mr = logic'(owner); bits = 0; idv = 0; ph = 1;
            end
            1: if (req == 0) ph = 0;
               else begin
                   idv = idv * 2 + ((owner == 1) ? s2 : s1);
                   bits++;
                   if (bits == L) begin
                       if (idv < N) begin e_sr = idv; rc = 0; ph = 2; end
                       else begin e_err = 1; ph = 3; end
                   end
               end
            2: if (req == 0) ph = 0;
               else begin
`ifdef ARB_TIMEOUT_EN
                   rc++;
                   if (rc == T) begin e_to = 1; last = owner; ph = 0; end
`endif
               end
            default: ph = 0;
        endcase
        e_g1   = (ph == 1 || ph == 2) && owner == 0;
        e_g2   = (ph == 1 || ph == 2) && owner == 1;
        e_rv   = (ph == 2);
        e_busy = (ph != 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m1_grant",     bus.m1_grant,     e_g1);
            chk("m2_grant",     bus.m2_grant,     e_g2);
            chk("arbiter_busy", bus.arbiter_busy, e_busy);
            chk("route_valid",  bus.route_valid,  e_rv);
            chk("arb_error",    bus.arb_error,    e_err);
            chk("arb_timeout",  bus.arb_timeout,  e_to);
            chk("grant_excl",   bus.m1_grant & bus.m2_grant, 0);
            if (e_rv) begin
                chk("master_route", bus.master_route, e_mr);
                chk("slave_route",  bus.slave_route,  e_sr);
                chk("rv_one_grant", bus.m1_grant ^ bus.m2_grant, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic setin(input logic r1, input logic r2, input logic s1, input logic s2);
        bus.m1_request = r1; bus.m2_request = r2;
        bus.m1_slave_sel = s1; bus.m2_slave_sel = s2;
    endtask

    task automatic do_reset();
        setin(0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int order [3];
        int who;
        bit got;
        logic rq1, rq2;

        setin(0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        #1 chk_en = 1'b1;
        chk("rst_m1_grant", bus.m1_grant, 0);
        chk("rst_m2_grant", bus.m2_grant, 0);
        chk("rst_busy",     bus.arbiter_busy, 0);
        chk("rst_slave_rt", bus.slave_route, 0);
        chk("rst_master_rt", bus.master_route, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single request, id 01
        setin(1, 0, 0, 0); tick();
        chk("single_grant", bus.m1_grant, 1);
        chk("single_rv0", bus.route_valid, 0);
        setin(1, 0, 0, 0); tick();
        chk("single_rv_early", bus.route_valid, 0);
        setin(1, 0, 1, 0); tick();
        chk("single_rv", bus.route_valid, 1);
        chk("single_sr", bus.slave_route, 1);
        chk("single_mr", bus.master_route, 0);
        setin(0, 0, 0, 0); tick();
        chk("single_drop_g", bus.m1_grant, 0);
        chk("single_drop_rv", bus.route_valid, 0);
        chk("single_drop_busy", bus.arbiter_busy, 0);

        // Round robin with both requesting, ids 00
        do_reset();
        setin(1, 1, 0, 0);
        for (int t = 0; t < 3; t++) begin
            got = 1'b0;
            for (int k = 0; k < 4 && !got; k++) begin
                if (bus.m1_grant || bus.m2_grant) got = 1'b1;
                else tick();
            end
            if (!got) got = bus.m1_grant || bus.m2_grant;
            chk("rr_grant_seen", got, 1);
            who = int'(bus.m2_grant);
            order[t] = who;
            tick(); tick();
            chk("rr_route", bus.route_valid, 1);
            if (who == 0) setin(0, 1, 0, 0); else setin(1, 0, 0, 0);
            tick();
            chk("rr_gap_grants", bus.m1_grant | bus.m2_grant, 0);
            chk("rr_gap_busy", bus.arbiter_busy, 0);
            setin(1, 1, 0, 0);
        end
        chk("rr_order0", order[0], 0);
        chk("rr_order1", order[1], 1);
        chk("rr_order2", order[2], 0);

        // Invalid id 11 from M2
        do_reset();
        setin(0, 1, 0, 1); tick();
        chk("err_grant", bus.m2_grant, 1);
        tick();
        chk("err_rv_mid", bus.route_valid, 0);
        tick();
        chk("err_grant_drop", bus.m2_grant, 0);
        chk("err_pulse", bus.arb_error, 1);
        chk("err_rv", bus.route_valid, 0);
        setin(0, 0, 0, 0); tick();
        chk("err_pulse_end", bus.arb_error, 0);
        chk("err_idle", bus.arbiter_busy, 0);

        // Abort after one id bit
        do_reset();
        setin(1, 0, 1, 0); tick(); tick();
        setin(0, 0, 0, 0); tick();
        chk("abort_grant", bus.m1_grant, 0);
        chk("abort_err", bus.arb_error, 0);
        chk("abort_rv", bus.route_valid, 0);
        tick();
        chk("abort_err2", bus.arb_error, 0);

        // Reset in the middle of ROUTE
        do_reset();
        setin(1, 0, 0, 0); tick(); tick(); tick();
        chk("mid_rv", bus.route_valid, 1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_grant", bus.m1_grant, 0);
        chk("mid_rst_rv", bus.route_valid, 0);
        chk("mid_rst_busy", bus.arbiter_busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        setin(1, 1, 0, 0); tick();
        chk("mid_after_m1", bus.m1_grant, 1);
        chk("mid_after_m2", bus.m2_grant, 0);

`ifdef ARB_TIMEOUT_EN
        // Forced release after T route cycles
        do_reset();
        setin(1, 0, 0, 0); tick(); tick(); tick();
        chk("to_rv", bus.route_valid, 1);
        setin(1, 1, 0, 0);
        for (int k = 1; k <= T; k++) begin
            tick();
            if (k < T) chk("to_hold", bus.m1_grant, 1);
        end
        chk("to_pulse", bus.arb_timeout, 1);
        chk("to_drop", bus.m1_grant, 0);
        tick();
        chk("to_pulse_end", bus.arb_timeout, 0);
        chk("to_m2_next", bus.m2_grant, 1);
`endif

        // Randomized masters
        do_reset();
        rq1 = 1'b0; rq2 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!rq1) rq1 = ($urandom_range(0, 2) == 0);
            else if (e_g1) rq1 = ($urandom_range(0, 7) != 0);
            else rq1 = ($urandom_range(0, 15) != 0);
            if (!rq2) rq2 = ($urandom_range(0, 2) == 0);
            else if (e_g2) rq2 = ($urandom_range(0, 7) != 0);
            else rq2 = ($urandom_range(0, 15) != 0);
            setin(rq1, rq2, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
            tick();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
- Two-master arbiter for the serial system bus; decides which master (M1 or M2) owns the bus and which slave (S1..S3) the interconnect routes to.
- Sits inside the bus interconnect between the master request/grant lines and the address/data/control mux select logic.
- Arbitration is round-robin. The slave select is shifted in serially from the granted master after grant.
- Drives the arbiter busy flag seen by every master.

Parameters:
- SLAVE_LEN, 2, width of the serial slave-id field and of the slave_route output.
- NUM_SLAVES, 3, number of valid slave ids (0..NUM_SLAVES-1); any id >= NUM_SLAVES is an error.
- TIMEOUT_CYCLES, 1024, maximum ROUTE duration in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m1_request  in  1  M1 bus request; held high for the whole transaction.
- m2_request  in  1  M2 bus request; held high for the whole transaction.
- m1_slave_sel  in  1  M1 serial slave id, MSB first, valid only after m1_grant.
- m2_slave_sel  in  1  M2 serial slave id, MSB first, valid only after m2_grant.
- m1_grant  out  1  M1 owns the bus.
- m2_grant  out  1  M2 owns the bus.
- arbiter_busy  out  1  high in every state except IDLE.
- master_route  out  1  0 = M1 drives the bus, 1 = M2; meaningful while route_valid.
- slave_route  out  SLAVE_LEN  selected slave id; meaningful while route_valid.
- route_valid  out  1  interconnect muxes are live.
- arb_error  out  1  one-cycle pulse when an invalid slave id is received.
- arb_timeout  out  1  one-cycle pulse on forced release (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- Reset (async): all outputs 0; state IDLE; bit counter 0; last_winner = M2, so M1 wins the first tie.
- All outputs are registered.
- States:
  - IDLE: arbitrate among requests.
  - SSEL: grant is high; shift in the slave id.
  - ROUTE: route_valid high until the owner drops its request.
  - ERR: single cycle; drop grant and pulse arb_error.
- IDLE:
  - Only one request high: that master wins.
  - Both high in the same cycle: the master that is not last_winner wins.
  - Neither high: stay in IDLE.
  - On the winning edge: assert the winner's grant, set master_route, update last_winner, clear the bit counter, go to SSEL.
- Grant to slave id timing:
  - Grant rises at edge E0.
  - The master drives the id MSB in the cycle after E0.
  - The arbiter samples one bit per edge, E1..E_SLAVE_LEN.
  - After E_SLAVE_LEN: if id < NUM_SLAVES, load slave_route, assert route_valid, go to ROUTE; otherwise go to ERR.
  - Grant-to-route_valid latency is SLAVE_LEN edges.
- ROUTE:
  - Owner's request low at an edge: grant, route_valid and arbiter_busy drop at that edge; state returns to IDLE.
  - A new grant can be issued one cycle later at the earliest. This is the mandatory turnaround; no back-to-back grants.
- ERR: grant and route_valid are 0; arb_error = 1 for one cycle; next state IDLE. The master must drop its request; a request still high is re-arbitrated normally.
- Owner drops its request during SSEL: abort to IDLE without pulsing arb_error; route_valid never rises.
- Non-owner request while not IDLE: ignored and not latched. It is evaluated again in IDLE.
- Grant rules:
  - m1_grant and m2_grant are never high together.
  - route_valid implies exactly one grant high.
- Reset asserted mid-transaction: immediate return to the reset values, regardless of state.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With it defined:
  - A cycle counter runs while in ROUTE.
  - When the counter reaches TIMEOUT_CYCLES: drop grant and route_valid, pulse arb_timeout for 1 cycle, go to IDLE, and set last_winner to the timed-out master so the other master has priority.
  - The counter clears on every entry to ROUTE.
- Without it: no counter is synthesized; arb_timeout is constant 0; ROUTE lasts until the request drops.

Decomposition:
- Shared package bus_arb_pkg holds:
  - the state encoding (IDLE, SSEL, ROUTE, ERR);
  - master id constants (MASTER_M1 = 0, MASTER_M2 = 1);
  - the default SLAVE_LEN and NUM_SLAVES values, shared with the master and slave modules.
- One sub-module: slave_id_shifter.
  - SLAVE_LEN-bit MSB-first shift register with bit counter.
  - Inputs: clear, shift enable and the serial bit.
  - Outputs: done and the id.
- The arbitration FSM stays in the top-level arbiter.

Test Plan:
- Single request:
  - Stimulus: m1_request = 1; after m1_grant, drive serial id 01.
  - Response: m1_grant is 1 the edge after the request; route_valid = 1, slave_route = 1, master_route = 0 two edges after grant.
  - Dropping the request clears grant, route_valid and arbiter_busy at the same edge.
- Simultaneous requests, round-robin:
  - Stimulus: both requests high from reset; both complete with id 00.
  - Response: grant order is M1, M2, M1 across three transactions; the grants never overlap; there is at least one idle cycle between grants.
- Invalid id:
  - Stimulus: M2 granted, drives id 11.
  - Response: 2 edges after grant, m2_grant = 0, arb_error is a 1-cycle pulse, route_valid stays 0 throughout, state returns to IDLE.
- Abort:
  - Stimulus: M1 drops its request after 1 id bit.
  - Response: grant drops at that edge; no arb_error; route_valid never rises.
- Reset mid-ROUTE:
  - Stimulus: assert reset asynchronously while M1 is in ROUTE.
  - Response: all outputs 0 before the next clock edge; after release with both requests high, M1 wins.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8:
  - Stimulus: M1 holds its request in ROUTE.
  - Response: after 8 cycles, arb_timeout pulses once and m1_grant drops; with both masters requesting, M2 is granted next.
